// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 multi-cycle controller: FSM states,
// opcode values and the mux-select encodings driven onto the datapath.
package mips_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_IEXEC  = 4'd10,
        ST_IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // States that hold a request on the memory port and wait for mem_ready.
    function automatic logic is_mem_state(state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mips_mc_watchdog.sv
// Memory-wait watchdog: counts consecutive stalled cycles in a memory state
// and flags a timeout once the count reaches WAIT_MAX (0 disables it).
module mips_mc_watchdog #(
    parameter int WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

    logic [CW-1:0] wait_cnt;

    assign timeout = (WAIT_MAX != 0) && active && !mem_ready && (wait_cnt == LIMIT);

    // Leaving a memory state always passes through mem_ready=1 or a
    // non-memory state, so clearing on those covers every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (active && !mem_ready && !timeout) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS32 control sequencer with memory-stall watchdog.
// Optional performance counters are enabled with `define MIPS_MC_PERF_EN.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int PERF_W   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state_o,
    output logic       illegal_op,
    output logic       mem_timeout
`ifdef MIPS_MC_PERF_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instr_cnt
`endif
);

    state_t state, next_state;
    logic   timeout;

    mips_mc_watchdog #(.WAIT_MAX(WAIT_MAX)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .active    (is_mem_state(state)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Decoding is skipped entirely while rst is low so every strobe reads 0.
    always_comb begin
        next_state  = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        state_o     = 4'd0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        if (rst) begin
            state_o = state;
            case (state)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    if (mem_ready) next_state = ST_DECODE;
                end
                ST_DECODE: begin
                    ALUSrcB = SRCB_IMM_SH2;
                    case (opcode)
                        OP_LW, OP_SW:    next_state = ST_MEMADR;
                        OP_RTYPE:        next_state = ST_EXEC;
                        OP_BEQ, OP_BNE:  next_state = ST_BRANCH;
                        OP_J:            next_state = ST_JUMP;
                        OP_ADDI:         next_state = ST_IEXEC;
                        default: begin
                            illegal_op = 1'b1;
                            next_state = ST_FETCH;
                        end
                    endcase
                end
                ST_MEMADR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_IMM;
                    next_state = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
                end
                ST_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    if (mem_ready) next_state = ST_MEMWB;
                end
                ST_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    next_state = ST_FETCH;
                end
                ST_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    if (mem_ready) next_state = ST_FETCH;
                end
                ST_EXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUOp      = ALUOP_FUNCT;
                    next_state = ST_ALUWB;
                end
                ST_ALUWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    next_state = ST_FETCH;
                end
                ST_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                    BranchNe    = opcode[0];
                    next_state  = ST_FETCH;
                end
                ST_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = PCSRC_JUMP;
                    next_state = ST_FETCH;
                end
                ST_IEXEC: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_IMM;
                    next_state = ST_IWB;
                end
                ST_IWB: begin
                    RegWrite   = 1'b1;
                    next_state = ST_FETCH;
                end
                default: next_state = ST_FETCH;
            endcase
            // An aborted access suppresses all strobes; FETCH keeps PC so it refetches.
            if (timeout) begin
                MemRead     = 1'b0;
                MemWrite    = 1'b0;
                IRWrite     = 1'b0;
                PCWrite     = 1'b0;
                RegWrite    = 1'b0;
                mem_timeout = 1'b1;
                next_state  = ST_FETCH;
            end
        end
    end

`ifdef MIPS_MC_PERF_EN
    logic instr_done;

    assign instr_done = (state == ST_MEMWB) || (state == ST_ALUWB) ||
                        (state == ST_BRANCH) || (state == ST_JUMP) ||
                        (state == ST_IWB) || ((state == ST_MEMWR) && mem_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + PERF_W'(1);
            if (instr_done) instr_cnt <= instr_cnt + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Table-driven bench for mips_mc_ctrl: per-cycle vectors of inputs and
// hand-computed state/control words, plus a mid-instruction reset sequence.
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_o;
    logic       illegal_op, mem_timeout;
`ifdef MIPS_MC_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.WAIT_MAX(4), .PERF_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .BranchNe    (BranchNe),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .state_o     (state_o),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
`ifdef MIPS_MC_PERF_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    // Control word layout: PCWrite PCWriteCond BranchNe IorD MemRead MemWrite IRWrite
    // MemtoReg RegDst RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] illegal_op mem_timeout
    logic [18:0] ctrl_act;
    assign ctrl_act = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                       illegal_op, mem_timeout};

    localparam logic [18:0] C_ZERO       = 19'd0;
    localparam logic [18:0] C_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd0,2'd0, 1'b0,1'b0};
    localparam logic [18:0] C_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd0,2'd0, 1'b0,1'b0};
    localparam logic [18:0] C_FETCH_TO   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd0,2'd0, 1'b0,1'b1};
    localparam logic [18:0] C_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd3,2'd0,2'd0, 1'b0,1'b0};
    localparam logic [18:0] C_DECODE_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd3,2'd0,2'd0, 1'b1,1'b0};
    localparam logic [18:0] C_MEMADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd2,2'd0,2'd0, 1'b0,1'b0};
    localparam logic [18:0] C_MEMRD      = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0, 1'b0,1'b0};
    localparam logic [18:0] C_MEMRD_TO   = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0, 1'b0,1'b1};
    localparam logic [18:0] C_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'd0,2'd0,2'd0, 1'b0,1'b0};
    localparam logic [18:0] C_MEMWR      = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0, 1'b0,1'b0};
    localparam logic [18:0] C_EXEC       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0,2'd2,2'd0, 1'b0,1'b0};
    localparam logic [18:0] C_ALUWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2'd0,2'd0,2'd0, 1'b0,1'b0};
    localparam logic [18:0] C_BEQ        = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0,2'd1,2'd1, 1'b0,1'b0};
    localparam logic [18:0] C_BNE        = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0,2'd1,2'd1, 1'b0,1'b0};
    localparam logic [18:0] C_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd2, 1'b0,1'b0};
    localparam logic [18:0] C_IEXEC      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd2,2'd0,2'd0, 1'b0,1'b0};
    localparam logic [18:0] C_IWB        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'd0,2'd0,2'd0, 1'b0,1'b0};

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ILL  = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctrl;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                           input logic [18:0] ctrl);
        vec_t v;
        v.op   = op;
        v.rdy  = rdy;
        v.st   = st;
        v.ctrl = ctrl;
        vecs.push_back(v);
    endtask

    task automatic add_fd(input logic [5:0] op);
        add_vec(op, 1'b1, 4'd0, C_FETCH_RDY);
        add_vec(op, 1'b1, 4'd1, C_DECODE);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one vector at the negedge, compare just after, then wait for the next negedge.
    task automatic apply_stimulus(input int idx, input vec_t v);
        opcode    = v.op;
        mem_ready = v.rdy;
        #1;
        check_output($sformatf("vec%0d_state", idx), 32'(state_o), 32'(v.st));
        check_output($sformatf("vec%0d_ctrl", idx), 32'(ctrl_act), 32'(v.ctrl));
        @(negedge clk);
    endtask

    initial begin
        // lw, no stalls: 5 cycles
        add_fd(LW);
        add_vec(LW, 1'b1, 4'd2, C_MEMADR);
        add_vec(LW, 1'b1, 4'd3, C_MEMRD);
        add_vec(LW, 1'b1, 4'd4, C_MEMWB);
        // sw with 3 stalled MEMWR cycles
        add_fd(SW);
        add_vec(SW, 1'b1, 4'd2, C_MEMADR);
        for (int i = 0; i < 3; i++) add_vec(SW, 1'b0, 4'd5, C_MEMWR);
        add_vec(SW, 1'b1, 4'd5, C_MEMWR);
        // branches and jump
        add_fd(BNE);
        add_vec(BNE, 1'b1, 4'd8, C_BNE);
        add_fd(BEQ);
        add_vec(BEQ, 1'b1, 4'd8, C_BEQ);
        add_fd(JMP);
        add_vec(JMP, 1'b1, 4'd9, C_JUMP);
        // R-type with mem_ready low where it must be ignored
        add_vec(RT, 1'b1, 4'd0, C_FETCH_RDY);
        add_vec(RT, 1'b0, 4'd1, C_DECODE);
        add_vec(RT, 1'b0, 4'd6, C_EXEC);
        add_vec(RT, 1'b0, 4'd7, C_ALUWB);
        // addi
        add_fd(ADDI);
        add_vec(ADDI, 1'b1, 4'd10, C_IEXEC);
        add_vec(ADDI, 1'b1, 4'd11, C_IWB);
        // illegal opcode
        add_vec(ILL, 1'b1, 4'd0, C_FETCH_RDY);
        add_vec(ILL, 1'b1, 4'd1, C_DECODE_ILL);
        // lw with one fetch stall and one read stall
        add_vec(LW, 1'b0, 4'd0, C_FETCH_WAIT);
        add_fd(LW);
        add_vec(LW, 1'b1, 4'd2, C_MEMADR);
        add_vec(LW, 1'b0, 4'd3, C_MEMRD);
        add_vec(LW, 1'b1, 4'd3, C_MEMRD);
        add_vec(LW, 1'b1, 4'd4, C_MEMWB);
        // lw aborted by the watchdog in MEMRD
        add_fd(LW);
        add_vec(LW, 1'b1, 4'd2, C_MEMADR);
        for (int i = 0; i < 4; i++) add_vec(LW, 1'b0, 4'd3, C_MEMRD);
        add_vec(LW, 1'b0, 4'd3, C_MEMRD_TO);
        // fetch timeout, then 4 more stalls without a second timeout
        for (int i = 0; i < 4; i++) add_vec(RT, 1'b0, 4'd0, C_FETCH_WAIT);
        add_vec(RT, 1'b0, 4'd0, C_FETCH_TO);
        for (int i = 0; i < 4; i++) add_vec(RT, 1'b0, 4'd0, C_FETCH_WAIT);
        add_fd(RT);
        add_vec(RT, 1'b1, 4'd6, C_EXEC);
        add_vec(RT, 1'b1, 4'd7, C_ALUWB);

        rst       = 1'b0;
        opcode    = LW;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_output("reset_state", 32'(state_o), 32'd0);
        check_output("reset_ctrl", 32'(ctrl_act), 32'(C_ZERO));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply_stimulus(i, vecs[i]);

        // Reset asserted mid-ALUWB: outputs drop immediately, FETCH restarts
        begin
            vec_t v;
            v.op = RT; v.rdy = 1'b1; v.st = 4'd0; v.ctrl = C_FETCH_RDY;
            apply_stimulus(1000, v);
            v.st = 4'd1; v.ctrl = C_DECODE;
            apply_stimulus(1001, v);
            v.st = 4'd6; v.ctrl = C_EXEC;
            apply_stimulus(1002, v);
            #1;
            check_output("midrst_pre_state", 32'(state_o), 32'd7);
            check_output("midrst_pre_ctrl", 32'(ctrl_act), 32'(C_ALUWB));
            #2;
            rst = 1'b0;
            #1;
            check_output("midrst_state", 32'(state_o), 32'd0);
            check_output("midrst_ctrl", 32'(ctrl_act), 32'(C_ZERO));
            @(negedge clk);
            #1;
            check_output("midrst_hold_ctrl", 32'(ctrl_act), 32'(C_ZERO));
`ifdef MIPS_MC_PERF_EN
            check_output("midrst_cycle_cnt", cycle_cnt, 32'd0);
            check_output("midrst_instr_cnt", instr_cnt, 32'd0);
`endif
            @(negedge clk);
            rst = 1'b1;
            v.st = 4'd0; v.ctrl = C_FETCH_RDY;
            apply_stimulus(1003, v);
            v.st = 4'd1; v.ctrl = C_DECODE;
            apply_stimulus(1004, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multi-cycle sequencer for the MIPS32 datapath: one ALU, one unified instruction/data memory port, PC and IR registers.
Decodes the opcode held in IR and steps the datapath through fetch/decode/execute/memory/writeback.
Issues every mux select and write strobe each cycle.
Stalls on a memory ready handshake, with a watchdog so a hung memory cannot lock the core.

Parameters:
WAIT_MAX, 255, max consecutive cycles a memory state waits for mem_ready before aborting; 0 disables the watchdog
PERF_W, 32, width of the performance counters (used only with the optional feature)

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-low
opcode  in  6  IR[31:26]
mem_ready  in  1  memory completes the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  conditional PC load (branch)
BranchNe  out  1  condition select: 0=beq (zero), 1=bne (~zero)
IorD  out  1  memory address: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR
MemtoReg  out  1  writeback data: 0=ALUOut, 1=MDR
RegDst  out  1  dest reg: 0=rt, 1=rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=rs
ALUSrcB  out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
ALUOp  out  2  0=add, 1=sub, 2=funct-decoded
PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target
state_o  out  4  current state (debug)
illegal_op  out  1  one-cycle pulse on unsupported opcode
mem_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- States (4-bit encoding): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11.
- Reset (rst=0, asynchronous): state=FETCH, watchdog count=0.
- While rst=0, every output is forced to 0; state_o=0.
- Outputs are combinational from state and mem_ready. Unlisted outputs are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0.
  - IRWrite=PCWrite=mem_ready.
  - Next: DECODE if mem_ready, else FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw), 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq), 000101 (bne) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> IEXEC
  - any other opcode -> FETCH, illegal_op=1 for that cycle
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next: MEMRD for lw, MEMWR for sw. The opcode is re-sampled; IR is stable.
- MEMRD: MemRead=1, IorD=1. Next: MEMWB when mem_ready, else hold.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next: FETCH.
- MEMWR: MemWrite=1, IorD=1. Next: FETCH when mem_ready, else hold.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Next: ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1, BranchNe=opcode[0]. Next: FETCH.
- JUMP: PCWrite=1, PCSource=2. Next: FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next: IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. Next: FETCH.
- Latency (with mem_ready=1 in the same cycle as the request):
  - j: 3 cycles
  - beq/bne: 3 cycles
  - R-type and addi: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles
  - Every mem_ready=0 cycle adds one cycle.
- Watchdog (FETCH, MEMRD, MEMWR only):
  - The counter increments each cycle mem_ready=0 in one of these states.
  - It clears on a state change or when mem_ready=1.
  - If WAIT_MAX!=0 and the counter equals WAIT_MAX while mem_ready=0: MemRead/MemWrite/IRWrite/PCWrite/RegWrite are 0 that cycle, mem_timeout=1, next state=FETCH, counter cleared.
  - A timeout in FETCH refetches from the unchanged PC.
- mem_ready is ignored in states that issue no memory request.
- Reset mid-instruction: the in-flight instruction is abandoned; no partial RegWrite/MemWrite can occur after rst falls.

Optional Feature:
Macro MIPS_MC_PERF_EN.
- Defined: adds outputs cycle_cnt[PERF_W-1:0] (counts every cycle out of reset) and instr_cnt[PERF_W-1:0].
  - instr_cnt increments on entry to FETCH from MEMWB, MEMWR(mem_ready), ALUWB, BRANCH, JUMP, IWB.
  - It does not increment on illegal or timeout returns.
  - Both counters wrap modulo 2^PERF_W and clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
Shared package mips_pkg holds:
- state enum
- opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI)
- ALUOp and ALUSrcB/PCSource encodings

One natural sub-module: mips_mc_watchdog (counter, compare, timeout pulse).

Test Plan:
- Reset release with opcode=100011, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in MEMWB; PCWrite=1 only in cycle 1.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite held 4 cycles, state stays 5, then FETCH; no RegWrite.
- opcode=000101 -> BRANCH with PCWriteCond=1, BranchNe=1, ALUOp=1, PCSource=1; opcode=000100 gives BranchNe=0.
- opcode=111111 in DECODE -> illegal_op one-cycle pulse, next FETCH, no RegWrite/MemWrite at any point.
- WAIT_MAX=4, mem_ready=0 in FETCH -> mem_timeout pulses in the 5th FETCH cycle, IRWrite never 1, FETCH re-entered with counter 0.
- rst low for 1 cycle during ALUWB -> all outputs 0 immediately, state_o=0; after release the FETCH sequence restarts (with MIPS_MC_PERF_EN: counters read 0).
